// File: rtl/apb4_master_bridge_if.sv
// rtl/apb4_master_bridge_if.sv - command/response and APB4 signal bundle for apb4_master_bridge
// Purpose: groups the command stream, response stream and APB4 bus of the bridge.
// Ports (master = bridge side):
//   cmd_*   : command stream into the bridge (valid/ready)
//   rsp_*   : response stream out of the bridge (valid/ready)
//   busy_o  : bridge not idle
//   p*      : APB4 initiator signals
interface apb4_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_write_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [DATA_WIDTH-1:0] cmd_wdata_i;
  logic [STRB_WIDTH-1:0] cmd_strb_i;
  logic [2:0]            cmd_prot_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  rsp_timeout_o;

  logic                  busy_o;

  logic [ADDR_WIDTH-1:0] paddr_o;
  logic [2:0]            pprot_o;
  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [DATA_WIDTH-1:0] pwdata_o;
  logic [STRB_WIDTH-1:0] pstrb_o;
  logic                  pready_i;
  logic [DATA_WIDTH-1:0] prdata_i;
  logic                  pslverr_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i, cmd_prot_i,
    input  rsp_ready_i, pready_i, prdata_i, pslverr_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, busy_o,
    output paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i, cmd_prot_i,
    output rsp_ready_i, pready_i, prdata_i, pslverr_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, busy_o,
    input  paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
  );
endinterface

// File: rtl/apb4_master_bridge.sv
// rtl/apb4_master_bridge.sv - command-stream to APB4 initiator bridge with pready timeout
// Purpose: turns each accepted command into one APB4 SETUP/ACCESS transfer and
// returns the result on the response stream; an ACCESS phase stretched by the
// slave for TIMEOUT_CYCLES cycles is aborted with err=1, timeout=1.
// Ports:
//   clk_i : bus clock
//   rst_i : asynchronous active-high reset
//   bus   : apb4_master_bridge_if.master (command, response and APB4 signals)
module apb4_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  apb4_master_bridge_if.master bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]            state_q,    state_d;
  logic [ADDR_WIDTH-1:0] paddr_q,    paddr_d;
  logic [2:0]            pprot_q,    pprot_d;
  logic                  pwrite_q,   pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q,   pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q,    pstrb_d;
  logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
  logic                  err_q,      err_d;
  logic                  timeout_q,  timeout_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;

  logic cmd_ready;
  logic cmd_fire;

  // A new command can be taken while the previous response is being consumed,
  // which is what gives the 3-cycle back-to-back throughput.
  assign cmd_ready = (state_q == ST_IDLE) | ((state_q == ST_RESP) & bus.rsp_ready_i);
  assign cmd_fire  = bus.cmd_valid_i & cmd_ready;

  always_comb begin
    state_d    = state_q;
    paddr_d    = paddr_q;
    pprot_d    = pprot_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    pstrb_d    = pstrb_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    timeout_d  = timeout_q;
    wait_cnt_d = wait_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // pready in the limit cycle still completes normally.
        if (bus.pready_i) begin
          rdata_d   = (!pwrite_q && !bus.pslverr_i) ? bus.prdata_i : '0;
          err_d     = bus.pslverr_i;
          timeout_d = 1'b0;
          state_d   = ST_RESP;
        end else if ((TIMEOUT_CYCLES > 0) && (wait_cnt_q == CNT_LIMIT)) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_RESP;
        end else if (TIMEOUT_CYCLES > 0) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready_i) state_d = cmd_fire ? ST_SETUP : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Command fields are only sampled on the handshake; the APB signals then
    // hold until the next accepted command.
    if (cmd_fire) begin
      paddr_d    = bus.cmd_addr_i & ~ADDR_WIDTH'(3);
      pprot_d    = bus.cmd_prot_i;
      pwrite_d   = bus.cmd_write_i;
      pwdata_d   = bus.cmd_write_i ? bus.cmd_wdata_i : '0;
      pstrb_d    = bus.cmd_write_i ? bus.cmd_strb_i : '0;
      wait_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      paddr_q    <= '0;
      pprot_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      paddr_q    <= paddr_d;
      pprot_q    <= pprot_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      pstrb_q    <= pstrb_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Strobes decode straight from state so reset drops them without a clock.
  assign bus.cmd_ready_o   = cmd_ready;
  assign bus.psel_o        = (state_q == ST_SETUP) | (state_q == ST_ACCESS);
  assign bus.penable_o     = (state_q == ST_ACCESS);
  assign bus.rsp_valid_o   = (state_q == ST_RESP);
  assign bus.busy_o        = (state_q != ST_IDLE);
  assign bus.paddr_o       = paddr_q;
  assign bus.pprot_o       = pprot_q;
  assign bus.pwrite_o      = pwrite_q;
  assign bus.pwdata_o      = pwdata_q;
  assign bus.pstrb_o       = pstrb_q;
  assign bus.rsp_rdata_o   = rdata_q;
  assign bus.rsp_err_o     = err_q;
  assign bus.rsp_timeout_o = timeout_q;
endmodule

// File: tb/tb_apb4_master_bridge.sv
// tb/tb_apb4_master_bridge.sv - self-checking bench for apb4_master_bridge
module tb_apb4_master_bridge;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  apb4_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb4_master_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] exp_paddr;
    logic [31:0] exp_pwdata;
    logic [3:0]  exp_pstrb;
    int          exp_access;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_timeout;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = v.write;
    bus.cmd_addr_i  = v.addr;
    bus.cmd_wdata_i = v.wdata;
    bus.cmd_strb_i  = v.strb;
    bus.cmd_prot_i  = v.prot;
    bus.rsp_ready_i = 1'b0;
    bus.pready_i    = 1'b0;
    #4;
    chk($sformatf("v%0d idle_cmd_ready", idx), bus.cmd_ready_o, 1);
    chk($sformatf("v%0d idle_psel", idx), bus.psel_o, 0);
    step();
    // scribble over the command inputs; the bridge must ignore them now
    bus.cmd_valid_i = 1'b0;
    bus.cmd_write_i = ~v.write;
    bus.cmd_addr_i  = 32'hFFFF_FFF0;
    bus.cmd_wdata_i = 32'h0;
    bus.cmd_strb_i  = 4'h0;
    bus.cmd_prot_i  = ~v.prot;
    #4;
    chk($sformatf("v%0d setup_psel", idx), bus.psel_o, 1);
    chk($sformatf("v%0d setup_penable", idx), bus.penable_o, 0);
    chk($sformatf("v%0d setup_paddr", idx), bus.paddr_o, v.exp_paddr);
    chk($sformatf("v%0d setup_pwrite", idx), bus.pwrite_o, v.write);
    chk($sformatf("v%0d setup_pwdata", idx), bus.pwdata_o, v.exp_pwdata);
    chk($sformatf("v%0d setup_pstrb", idx), bus.pstrb_o, v.exp_pstrb);
    chk($sformatf("v%0d setup_pprot", idx), bus.pprot_o, v.prot);
    chk($sformatf("v%0d setup_busy", idx), bus.busy_o, 1);
    step();
    n = 0;
    while (bus.penable_o && n < 20) begin
      if (n == v.waits) begin
        bus.pready_i  = 1'b1;
        bus.prdata_i  = v.prdata;
        bus.pslverr_i = v.slverr;
      end else begin
        bus.pready_i  = 1'b0;
        bus.prdata_i  = 32'hBAD0_BAD0;
        bus.pslverr_i = 1'b1;
      end
      #4;
      chk($sformatf("v%0d access_psel", idx), bus.psel_o, 1);
      chk($sformatf("v%0d access_paddr", idx), bus.paddr_o, v.exp_paddr);
      chk($sformatf("v%0d access_pwdata", idx), bus.pwdata_o, v.exp_pwdata);
      n++;
      step();
    end
    bus.pready_i  = 1'b0;
    bus.pslverr_i = 1'b0;
    bus.prdata_i  = 32'h0;
    chk($sformatf("v%0d access_cycles", idx), n, v.exp_access);
    #4;
    chk($sformatf("v%0d rsp_valid", idx), bus.rsp_valid_o, 1);
    chk($sformatf("v%0d rsp_rdata", idx), bus.rsp_rdata_o, v.exp_rdata);
    chk($sformatf("v%0d rsp_err", idx), bus.rsp_err_o, v.exp_err);
    chk($sformatf("v%0d rsp_timeout", idx), bus.rsp_timeout_o, v.exp_timeout);
    chk($sformatf("v%0d rsp_psel", idx), bus.psel_o, 0);
    chk($sformatf("v%0d rsp_penable", idx), bus.penable_o, 0);
    chk($sformatf("v%0d rsp_cmd_ready_low", idx), bus.cmd_ready_o, 0);
    bus.rsp_ready_i = 1'b1;
    #1;
    chk($sformatf("v%0d rsp_cmd_ready_comb", idx), bus.cmd_ready_o, 1);
    step();
    bus.rsp_ready_i = 1'b0;
    #4;
    chk($sformatf("v%0d done_rsp_valid", idx), bus.rsp_valid_o, 0);
    chk($sformatf("v%0d done_busy", idx), bus.busy_o, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //        wr    addr          wdata         strb  prot  waits prdata        slverr paddr         pwdata        pstrb acc rdata         err   to
    vecs[0] = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 3'd0, 0,  32'hFFFF_FFFF, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 1, 32'h0,         1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_000C, 32'h0000_0055, 4'h0, 3'd2, 3,  32'h1234_5678, 1'b0, 32'h0000_000C, 32'h0,         4'h0, 4, 32'h1234_5678, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_000F, 32'hA5A5_A5A5, 4'hF, 3'd1, 0,  32'hCAFE_0001, 1'b0, 32'h0000_000C, 32'h0,         4'h0, 1, 32'hCAFE_0001, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 3'd0, 99, 32'h0,         1'b0, 32'h0000_0100, 32'h0,         4'h0, 4, 32'h0,         1'b1, 1'b1};
    vecs[4] = '{1'b1, 32'h0000_1236, 32'h0000_00AA, 4'h1, 3'd7, 4,  32'h5555_5555, 1'b0, 32'h0000_1234, 32'h0000_00AA, 4'h1, 4, 32'h0,         1'b1, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'h6, 3'd3, 1,  32'h7777_7777, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'h6, 2, 32'h0,         1'b1, 1'b0};
    vecs[6] = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 3'd0, 2,  32'h0000_9999, 1'b1, 32'h0000_0024, 32'h0,         4'h0, 3, 32'h0,         1'b1, 1'b0};

    rst             = 1'b1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_write_i = 1'b0;
    bus.cmd_addr_i  = 32'h0;
    bus.cmd_wdata_i = 32'h0;
    bus.cmd_strb_i  = 4'h0;
    bus.cmd_prot_i  = 3'd0;
    bus.rsp_ready_i = 1'b0;
    bus.pready_i    = 1'b0;
    bus.prdata_i    = 32'h0;
    bus.pslverr_i   = 1'b0;
    step();
    chk("reset cmd_ready", bus.cmd_ready_o, 1);
    chk("reset psel", bus.psel_o, 0);
    chk("reset penable", bus.penable_o, 0);
    chk("reset rsp_valid", bus.rsp_valid_o, 0);
    chk("reset busy", bus.busy_o, 0);
    chk("reset paddr", bus.paddr_o, 0);
    chk("reset pwdata", bus.pwdata_o, 0);
    chk("reset rsp_err", bus.rsp_err_o, 0);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // pslverr write, response stalled, then back-to-back command on release
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = 1'b1;
    bus.cmd_addr_i  = 32'h0000_0030;
    bus.cmd_wdata_i = 32'h0BAD_F00D;
    bus.cmd_strb_i  = 4'hF;
    bus.cmd_prot_i  = 3'd0;
    step();
    bus.cmd_valid_i = 1'b0;
    step();
    bus.pready_i  = 1'b1;
    bus.pslverr_i = 1'b1;
    step();
    bus.pready_i    = 1'b0;
    bus.pslverr_i   = 1'b0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = 1'b0;
    bus.cmd_addr_i  = 32'h0000_0040;
    bus.cmd_wdata_i = 32'h0;
    bus.cmd_strb_i  = 4'h0;
    for (int c = 0; c < 5; c++) begin
      #4;
      chk($sformatf("stall%0d rsp_valid", c), bus.rsp_valid_o, 1);
      chk($sformatf("stall%0d rsp_err", c), bus.rsp_err_o, 1);
      chk($sformatf("stall%0d cmd_ready", c), bus.cmd_ready_o, 0);
      chk($sformatf("stall%0d paddr", c), bus.paddr_o, 32'h30);
      step();
    end
    bus.rsp_ready_i = 1'b1;
    #1;
    chk("b2b cmd_ready", bus.cmd_ready_o, 1);
    chk("b2b rsp_valid", bus.rsp_valid_o, 1);
    step();
    bus.rsp_ready_i = 1'b0;
    bus.cmd_valid_i = 1'b0;
    #4;
    chk("b2b setup_psel", bus.psel_o, 1);
    chk("b2b setup_penable", bus.penable_o, 0);
    chk("b2b setup_paddr", bus.paddr_o, 32'h40);
    chk("b2b setup_pwrite", bus.pwrite_o, 0);
    chk("b2b rsp_valid_low", bus.rsp_valid_o, 0);
    step();
    bus.pready_i = 1'b1;
    bus.prdata_i = 32'h600D_CAFE;
    #4;
    chk("b2b access_penable", bus.penable_o, 1);
    step();
    bus.pready_i = 1'b0;
    bus.prdata_i = 32'h0;
    #4;
    chk("b2b rsp_valid", bus.rsp_valid_o, 1);
    chk("b2b rsp_rdata", bus.rsp_rdata_o, 32'h600D_CAFE);
    chk("b2b rsp_err", bus.rsp_err_o, 0);
    bus.rsp_ready_i = 1'b1;
    step();
    bus.rsp_ready_i = 1'b0;
    #4;
    chk("b2b idle_busy", bus.busy_o, 0);
    step();

    // reset asserted mid-ACCESS
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = 1'b0;
    bus.cmd_addr_i  = 32'h0000_0050;
    step();
    bus.cmd_valid_i = 1'b0;
    step();
    bus.pready_i = 1'b0;
    #2;
    chk("rst pre_penable", bus.penable_o, 1);
    rst = 1'b1;
    #1;
    chk("rst async_psel", bus.psel_o, 0);
    chk("rst async_penable", bus.penable_o, 0);
    chk("rst async_rsp_valid", bus.rsp_valid_o, 0);
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #4;
      chk($sformatf("post_rst%0d rsp_valid", c), bus.rsp_valid_o, 0);
      chk($sformatf("post_rst%0d cmd_ready", c), bus.cmd_ready_o, 1);
      chk($sformatf("post_rst%0d psel", c), bus.psel_o, 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb4_master_bridge.md
Name: apb4_master_bridge

Overview:
Command-driven APB4 initiator. It converts a simple valid/ready command stream into compliant APB4 SETUP/ACCESS transfers and returns each result on a valid/ready response stream. It lets on-chip controllers and test sequencers drive APB4 peripherals such as the RTC, timers and UART. Slaves that stretch pready indefinitely are bounded by a built-in timeout.

Parameters:
ADDR_WIDTH, 32, APB address width (min 3)
DATA_WIDTH, 32, APB data width (8/16/32); STRB_WIDTH = DATA_WIDTH/8
TIMEOUT_CYCLES, 256, max ACCESS cycles with pready low before abort; 0 disables timeout

Ports:
clk_i  in  1  bus clock
rst_i  in  1  asynchronous, active-high reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_write_i  in  1  1=write, 0=read
cmd_addr_i  in  ADDR_WIDTH  byte address
cmd_wdata_i  in  DATA_WIDTH  write data
cmd_strb_i  in  STRB_WIDTH  write byte strobes
cmd_prot_i  in  3  pprot value
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes, errors, timeouts)
rsp_err_o  out  1  pslverr sampled, or timeout
rsp_timeout_o  out  1  transfer aborted by timeout
busy_o  out  1  state != IDLE
paddr_o  out  ADDR_WIDTH  APB address
pprot_o  out  3  APB protection
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction
pwdata_o  out  DATA_WIDTH  APB write data
pstrb_o  out  STRB_WIDTH  APB strobes
pready_i  in  1  slave ready
prdata_i  in  DATA_WIDTH  slave read data
pslverr_i  in  1  slave error

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE. All outputs 0, except cmd_ready_o=1 in IDLE.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- cmd_ready_o = (state==IDLE) | (state==RESP & rsp_ready_i). The combinational rsp_ready_i->cmd_ready_o path is intended.
- On command handshake, latch the command into internal registers and move to SETUP on the next edge.
- Address/data formatting:
  - paddr_o = {addr[ADDR_WIDTH-1:2],2'b00}.
  - pstrb_o = strb for writes, 0 for reads.
  - pwdata_o = wdata for writes, 0 for reads.
- paddr/pwrite/pwdata/pstrb/pprot are stable from SETUP through the last ACCESS cycle. They are held afterwards and only change on a new command.
- SETUP: psel=1, penable=0, exactly one cycle, then ACCESS.
- ACCESS: psel=1, penable=1.
  - pready_i=1 sampled: capture rdata (prdata_i for reads, else 0), err=pslverr_i, timeout=0, go to RESP.
  - pready_i=0: increment the wait counter (width $clog2(TIMEOUT_CYCLES+1)), stay in ACCESS.
- Timeout (TIMEOUT_CYCLES>0): if the counter reaches TIMEOUT_CYCLES-1 with pready_i still 0 in that cycle, abort.
  - Next cycle: psel=penable=0.
  - Response: err=1, timeout=1, rdata=0.
  - If pready_i=1 in the limit cycle, the normal completion wins.
- Counter clears on entry to SETUP.
- RESP: psel=penable=0, rsp_valid_o=1. Outputs are held stable until rsp_ready_i.
  - On rsp handshake, go to SETUP if a command is accepted in the same cycle, else IDLE.
- Latency: command accepted at cycle N -> SETUP N+1 -> ACCESS N+2 -> rsp_valid_o at N+3 with zero wait states. Back-to-back throughput is one transfer per 3 cycles.
- psel_o is never high for two transfers without passing through SETUP (penable=0).
- Reset asserted mid-transfer:
  - psel/penable drop asynchronously.
  - The in-flight command is discarded and no response is produced.
- cmd_* inputs are ignored outside a handshake cycle.
- busy_o=1 in SETUP, ACCESS and RESP.

Test Plan:
- Write addr=0x0000_0008, wdata=0xDEAD_BEEF, strb=0xF, slave pready=1 immediately:
  - paddr=0x08, pwrite=1 in SETUP (N+1) and ACCESS (N+2).
  - rsp_valid at N+3 with err=0, rdata=0.
- Read addr=0x0C, slave inserts 3 wait states then prdata=0x1234_5678:
  - penable high for 4 cycles.
  - rsp_rdata=0x1234_5678, err=0.
- Read with unaligned addr=0x0F and strb=0xF: paddr_o=0x0C, pstrb_o=0, pwdata_o=0.
- TIMEOUT_CYCLES=4, pready held 0:
  - Exactly 4 ACCESS cycles, then psel=0.
  - rsp err=1, timeout=1, rdata=0.
  - Repeat with pready=1 on the 4th cycle: normal completion, timeout=0.
- pslverr=1 on a write, then rsp_ready held low 5 cycles:
  - rsp_valid/err stable throughout, cmd_ready=0.
  - On rsp_ready=1 with cmd_valid=1: cmd_ready=1 same cycle, next cycle SETUP.
- Assert rst_i during ACCESS: psel/penable=0 immediately, rsp_valid stays 0, cmd_ready=1 after release.
